// File: rtl/vip_reset_release_seq.sv
`timescale 1ns/1ps
// Purpose: turns the VIP hard reset into a clock-synchronised rst_sync plus NUM_STAGES index-ordered domain resets.
// Latency: rst_sync drops SYNC_STAGES edges after reset falls (edge E); stage i drops at E+HOLD_CYCLES+i*STAGE_GAP; done one edge later.
// Backpressure: none, all outputs are free-running levels; VIP_RESET_SOFT_REQ_EN adds the soft_req re-sequence port.
module vip_reset_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 3,
  parameter int NUM_STAGES  = 3,
  parameter int CNT_W       = 8,
  parameter int SOFT_CYCLES = 5
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef VIP_RESET_SOFT_REQ_EN
  input  logic                  soft_req,
`endif
  output logic                  rst_sync,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  done,
  output logic [CNT_W-1:0]      seq_count
);

  // One down-counter serves every timed phase, so it is sized for the longest one.
  localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_CYC = (MAX_HG > SOFT_CYCLES) ? MAX_HG : SOFT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // Loads are "length - 1" because the edge that loads the counter is itself the phase start.
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(STAGE_GAP - 1);
`ifdef VIP_RESET_SOFT_REQ_EN
  localparam logic [TMR_W-1:0] SOFT_LOAD = TMR_W'(SOFT_CYCLES - 1);
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] ST_ASSERTED = 3'd0;
  localparam logic [2:0] ST_HOLD     = 3'd1;
  localparam logic [2:0] ST_RELEASE  = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef VIP_RESET_SOFT_REQ_EN
  localparam logic [2:0] ST_SOFT     = 3'd4;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_release_next;

  logic [2:0]             state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [NUM_STAGES-1:0]  stage_q, stage_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Reset synchroniser: asserts with reset, shifts zeros in so deassertion lands on a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // The chain's last flop will clear on this edge: lets the sequencer leave ASSERTED on edge E itself.
  assign sync_release_next = ~sync_q[SYNC_STAGES-2];

  // Sequencer next-state: stage bits clear by shifting zeros in from bit 0, so release order is by index.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    stage_d = stage_q;
    done_d  = done_q;
    count_d = count_q;
    case (state_q)
      ST_ASSERTED: begin
        if (sync_release_next) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          stage_d = stage_q << 1;
          state_d = ST_RELEASE;
          tmr_d   = GAP_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stage_q == '0) begin
          // All domains already out of reset: completion is flagged one edge after the last release.
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
          end
        end else if (tmr_q == '0) begin
          stage_d = stage_q << 1;
          tmr_d   = GAP_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DONE: begin
`ifdef VIP_RESET_SOFT_REQ_EN
        if (soft_req) begin
          state_d = ST_SOFT;
          stage_d = '1;
          done_d  = 1'b0;
          tmr_d   = SOFT_LOAD;
        end
`endif
      end
`ifdef VIP_RESET_SOFT_REQ_EN
      ST_SOFT: begin
        // The edge that leaves SOFT acts as a fresh E for the hold/release timing.
        if (tmr_q == '0) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      default: begin
        // Unreachable encodings fall back to a full re-sequence with every domain held.
        state_d = ST_ASSERTED;
        stage_d = '1;
        done_d  = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  // Sequencer state: hard reset returns every output to its held value immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_ASSERTED;
      tmr_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign stage_rst = stage_q;
  assign done      = done_q;
  assign seq_count = count_q;

endmodule

// File: tb/tb_vip_reset_release_seq.sv
`timescale 1ns/1ps
// Bench for vip_reset_release_seq: constant vector table, hand-written corner sequences,
// and randomized reset/soft stimulus compared with a timeline model of the release schedule.
module tb_vip_reset_release_seq;

  localparam int SYNC = 2;
  localparam int H    = 4;
  localparam int G    = 3;
  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int S    = 5;
  localparam int T    = H + (N - 1) * G + 1;  // edges from E to done
  localparam int CMAX = (1 << CW) - 1;
`ifdef VIP_RESET_SOFT_REQ_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // default-parameter instance
  logic          rst_a, soft_a;
  logic          rs_a;
  logic [N-1:0]  st_a;
  logic          done_a;
  logic [CW-1:0] cnt_a;

  // single-stage, one-cycle-hold instance
  logic          rst_b;
  logic          rs_b;
  logic [0:0]    st_b;
  logic          done_b;
  logic [7:0]    cnt_b;

  vip_reset_release_seq dut_a (
    .clock     (clock),
    .reset     (rst_a),
`ifdef VIP_RESET_SOFT_REQ_EN
    .soft_req  (soft_a),
`endif
    .rst_sync  (rs_a),
    .stage_rst (st_a),
    .done      (done_a),
    .seq_count (cnt_a)
  );

  vip_reset_release_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1)) dut_b (
    .clock     (clock),
    .reset     (rst_b),
`ifdef VIP_RESET_SOFT_REQ_EN
    .soft_req  (1'b0),
`endif
    .rst_sync  (rs_b),
    .stage_rst (st_b),
    .done      (done_b),
    .seq_count (cnt_b)
  );

`ifdef VIP_RESET_SOFT_REQ_EN
  // narrow-counter instance for saturation under repeated soft sequences
  logic       rst_c, soft_c;
  logic       rs_c;
  logic [2:0] st_c;
  logic       done_c;
  logic [1:0] cnt_c;

  vip_reset_release_seq #(.CNT_W(2)) dut_c (
    .clock     (clock),
    .reset     (rst_c),
    .soft_req  (soft_c),
    .rst_sync  (rs_c),
    .stage_rst (st_c),
    .done      (done_c),
    .seq_count (cnt_c)
  );
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string name, input logic rs, input logic [N-1:0] st, input logic d, input logic [CW-1:0] c);
    chk({name, ".rst_sync"},  32'(rs_a),   32'(rs));
    chk({name, ".stage_rst"}, 32'(st_a),   32'(st));
    chk({name, ".done"},      32'(done_a), 32'(d));
    chk({name, ".seq_count"}, 32'(cnt_a),  32'(c));
  endtask

  // Reference model: schedule expressed as edge counts.
  // m_n = edges since reset fell, m_e = edge count of the current E (-1 before the first one).
  // A soft request moves E to S edges after the edge that sampled it; before E every domain is held.
  int m_n = 0;
  int m_e = -1;
  int m_cnt = 0;

  function automatic bit m_done();
    return (m_e >= 0) && ((m_n - m_e) >= T);
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_e = -1;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic r, input logic s);
    bit was_done;
    bit soft_hit;
    if (r) begin
      model_reset();
      return;
    end
    was_done = m_done();
    soft_hit = SOFT_EN && s && was_done;
    m_n++;
    if (m_e < 0 && m_n == SYNC) m_e = m_n;
    if (soft_hit) m_e = m_n + S;
    else if (m_e >= 0 && (m_n - m_e) == T && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic chk_model(input string name);
    logic [N-1:0] est;
    for (int i = 0; i < N; i++)
      est[i] = !((m_e >= 0) && ((m_n - m_e) >= H + i * G));
    chk_a(name, (m_n < SYNC), est, m_done(), CW'(m_cnt));
  endtask

  task automatic tick_a(input logic r, input logic s);
    @(negedge clock);
    rst_a  = r;
    soft_a = s;
    @(posedge clock);
    model_edge(r, s);
    #1;
  endtask

  // Reset pulse entirely between two edges.
  task automatic glitch_a();
    @(negedge clock);
    soft_a = 1'b0;
    #2 rst_a = 1'b1;
    #1 model_reset();
    chk_model("glitch");
    #1 rst_a = 1'b0;
    @(posedge clock);
    model_edge(1'b0, 1'b0);
    #1;
  endtask

  task automatic tick_b(input logic r);
    @(negedge clock);
    rst_b = r;
    @(posedge clock);
    #1;
  endtask

`ifdef VIP_RESET_SOFT_REQ_EN
  task automatic tick_c(input logic r, input logic s);
    @(negedge clock);
    rst_c  = r;
    soft_c = s;
    @(posedge clock);
    #1;
  endtask
`endif

  typedef struct {
    logic       r;
    logic       s;
    logic       rs;
    logic [2:0] st;
    logic       d;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic r, input logic s, input logic rs,
                                  input logic [2:0] st, input logic d, input logic [7:0] c);
    vec_t v;
    v.r = r; v.s = s; v.rs = rs; v.st = st; v.d = d; v.c = c;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; soft_a = 1'b0;
`ifdef VIP_RESET_SOFT_REQ_EN
    rst_c = 1'b0; soft_c = 1'b0;
`endif
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
`ifdef VIP_RESET_SOFT_REQ_EN
    rst_c = 1'b1;
`endif
    #1;
    chk_a("reset_async", 1'b1, 3'b111, 1'b0, 8'd0);

    // Release schedule with defaults: E is the 2nd edge after reset falls.
    repeat (3) add_vec(1, 0, 1, 3'b111, 0, 0);
    add_vec(0, 0, 1, 3'b111, 0, 0);               // edge 1
    repeat (4) add_vec(0, 0, 0, 3'b111, 0, 0);    // E .. E+3
    repeat (3) add_vec(0, 0, 0, 3'b110, 0, 0);    // E+4 .. E+6
    repeat (3) add_vec(0, 0, 0, 3'b100, 0, 0);    // E+7 .. E+9
    add_vec(0, 0, 0, 3'b000, 0, 0);               // E+10
    repeat (2) add_vec(0, 0, 0, 3'b000, 1, 1);    // E+11, E+12

    foreach (vecs[i]) begin
      tick_a(vecs[i].r, vecs[i].s);
      chk_a($sformatf("vec%0d", i), vecs[i].rs, vecs[i].st, vecs[i].d, vecs[i].c);
    end

    // Hard reset between stage 1 and stage 2 release.
    tick_a(1, 0);
    tick_a(1, 0);
    repeat (10) tick_a(0, 0);                     // ends at E+8
    chk_a("abort_pre", 1'b0, 3'b100, 1'b0, 8'd0);
    @(negedge clock);
    rst_a = 1'b1;
    #1;
    chk_a("abort_now", 1'b1, 3'b111, 1'b0, 8'd0);
    tick_a(1, 0);
    repeat (12) tick_a(0, 0);                     // E+10
    chk_a("abort_e10", 1'b0, 3'b000, 1'b0, 8'd0);
    tick_a(0, 0);                                 // E+11
    chk_a("abort_done", 1'b0, 3'b000, 1'b1, 8'd1);
    repeat (3) tick_a(0, 0);
    chk_a("abort_stay", 1'b0, 3'b000, 1'b1, 8'd1);

    // Soft request during HOLD is ignored.
    tick_a(1, 0);
    repeat (4) tick_a(0, 0);                      // E+2
    tick_a(0, 1);                                 // E+3
    tick_a(0, 0);                                 // E+4
    chk_a("hold_soft_e4", 1'b0, 3'b110, 1'b0, 8'd0);
    repeat (7) tick_a(0, 0);                      // E+11
    chk_a("hold_soft_done", 1'b0, 3'b000, 1'b1, 8'd1);

`ifdef VIP_RESET_SOFT_REQ_EN
    // Soft request in DONE: sampled edge is D+1.
    tick_a(0, 1);
    chk_a("soft_enter", 1'b0, 3'b111, 1'b0, 8'd1);
    for (int k = 1; k <= 16; k++) begin
      tick_a(0, 0);
      chk("soft_rst_sync", 32'(rs_a), 32'd0);
      if (k == 8)  chk("soft_st_d9",    32'(st_a),   32'b111);
      if (k == 9)  chk("soft_st_d10",   32'(st_a),   32'b110);
      if (k == 15) chk("soft_done_d16", 32'(done_a), 32'd0);
      if (k == 16) chk_a("soft_done_d17", 1'b0, 3'b000, 1'b1, 8'd2);
    end
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 2) glitch_a();
      else tick_a(p < 5, $urandom_range(0, 99) < 20);
      chk_model($sformatf("rnd%0d", i));
    end
    tick_a(1, 0);

    // One stage, one hold cycle.
    tick_b(1);
    tick_b(0);
    chk("n1_edge1_rs", 32'(rs_b), 32'd1);
    tick_b(0);
    chk("n1_e_rs", 32'(rs_b), 32'd0);
    chk("n1_e_st", 32'(st_b), 32'd1);
    tick_b(0);
    chk("n1_e1_st",   32'(st_b),   32'd0);
    chk("n1_e1_done", 32'(done_b), 32'd0);
    tick_b(0);
    chk("n1_e2_done", 32'(done_b), 32'd1);
    chk("n1_e2_cnt",  32'(cnt_b),  32'd1);

`ifdef VIP_RESET_SOFT_REQ_EN
    // Two-bit counter saturates across soft re-sequences.
    begin
      logic [1:0] exp_cnt [4];
      exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
      tick_c(1, 0);
      repeat (13) tick_c(0, 0);
      chk("sat_first_done", 32'(done_c), 32'd1);
      chk("sat_first_cnt",  32'(cnt_c),  32'd1);
      for (int j = 0; j < 4; j++) begin
        tick_c(0, 1);
        repeat (16) tick_c(0, 0);
        chk($sformatf("sat_done%0d", j), 32'(done_c), 32'd1);
        chk($sformatf("sat_cnt%0d", j),  32'(cnt_c),  32'(exp_cnt[j]));
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
